// File: rtl/egr_wadj_pkt_arb.sv
// egr_wadj_pkt_arb: packet-atomic round-robin arbiter feeding the egress segment-split stage
package packet_switch_pkg;
  typedef struct packed {
    logic [5:0] seg_len;
    logic       sop;
    logic       eop;
  } SEGMENT_INFO_S;
endpackage

module egr_wadj_pkt_arb #(
  parameter int NUM_PORTS          = 4,
  parameter int TDATA_WIDTH        = 512,
  parameter int USERMETADATA_WIDTH = 1,
  parameter int MAX_BEATS          = 256,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [NUM_PORTS-1:0]                                in_tvalid,
  input  logic [NUM_PORTS-1:0][TDATA_WIDTH-1:0]               in_tdata,
  input  logic [NUM_PORTS-1:0][TDATA_WIDTH/8-1:0]             in_tkeep,
  input  logic [NUM_PORTS-1:0]                                in_tlast,
  input  logic [NUM_PORTS-1:0][USERMETADATA_WIDTH-1:0]        in_tuser_usermetadata,
  input  packet_switch_pkg::SEGMENT_INFO_S [NUM_PORTS-1:0]    in_tuser_segment_info,
  output logic [NUM_PORTS-1:0]                                in_tready,
  output logic                                                out_tvalid,
  output logic [TDATA_WIDTH-1:0]                              out_tdata,
  output logic [TDATA_WIDTH/8-1:0]                            out_tkeep,
  output logic                                                out_tlast,
  output logic [USERMETADATA_WIDTH-1:0]                       out_tuser_usermetadata,
  output packet_switch_pkg::SEGMENT_INFO_S                    out_tuser_segment_info,
  input  logic                                                out_tready,
  output logic [GW-1:0]                                       cur_grant,
  output logic                                                busy,
  output logic                                                wdog_evt
);
  localparam logic [0:0] S_IDLE = 1'b0, S_BUSY = 1'b1;
  logic [0:0]    r_state;
  logic [GW-1:0] r_last, w_pick;
  logic [CW-1:0] r_cnt;
  logic          w_acc, w_end, w_force;
  packet_switch_pkg::SEGMENT_INFO_S w_seg;
  // later candidates overwrite earlier ones, so the nearest port after r_last wins
  always_comb begin
    w_pick = r_last;
    for (int i = NUM_PORTS; i >= 1; i--)
      if (in_tvalid[GW'((int'(r_last) + i) % NUM_PORTS)]) w_pick = GW'((int'(r_last) + i) % NUM_PORTS);
  end
  always_comb begin
    in_tready = (r_state == S_BUSY && (!out_tvalid || out_tready)) ? {{(NUM_PORTS-1){1'b0}}, 1'b1} << cur_grant : '0;
    w_acc     = |(in_tvalid & in_tready);
    w_end     = w_acc && (in_tlast[cur_grant] || r_cnt == CW'(MAX_BEATS - 1));
    w_force   = w_end && !in_tlast[cur_grant];
    w_seg     = in_tuser_segment_info[cur_grant];
    w_seg.eop = w_seg.eop | w_force;
  end
  assign busy = r_state == S_BUSY;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      out_tvalid <= 1'b0;
      cur_grant  <= '0;
      r_last     <= GW'(NUM_PORTS - 1);
      r_cnt      <= '0;
      wdog_evt   <= 1'b0;
    end else begin
      wdog_evt   <= w_force;
      out_tvalid <= w_acc || (out_tvalid && !out_tready);
      if (r_state == S_IDLE) begin
        if (|in_tvalid) begin
          cur_grant <= w_pick;
          r_state   <= S_BUSY;
        end
      end else if (w_end) begin
        r_state <= S_IDLE;
        r_last  <= cur_grant;
        r_cnt   <= '0;
      end else if (w_acc) r_cnt <= r_cnt + CW'(1);
    end
  end
  // payload needs no reset; only out_tvalid qualifies it
  always_ff @(posedge clk) begin
    if (w_acc) begin
      out_tdata              <= in_tdata[cur_grant];
      out_tkeep              <= in_tkeep[cur_grant];
      out_tlast              <= in_tlast[cur_grant] | w_force;
      out_tuser_usermetadata <= in_tuser_usermetadata[cur_grant];
      out_tuser_segment_info <= w_seg;
    end
  end
endmodule

// File: tb/tb_egr_wadj_pkt_arb.sv
// tb_egr_wadj_pkt_arb: randomized bench with a packet-level round-robin reference model
module tb_egr_wadj_pkt_arb;
  localparam int NP = 4, DW = 32, UW = 1, MB = 4, GW = 2;
  typedef struct packed {
    logic [DW-1:0]   d;
    logic [DW/8-1:0] k;
    logic            l;
    logic [UW-1:0]   u;
    packet_switch_pkg::SEGMENT_INFO_S s;
  } beat_t;
  logic clk = 0, rst = 1;
  logic [NP-1:0] in_tvalid = '0, in_tlast = '0, in_tready;
  logic [NP-1:0][DW-1:0] in_tdata = '0;
  logic [NP-1:0][DW/8-1:0] in_tkeep = '0;
  logic [NP-1:0][UW-1:0] in_tuser_usermetadata = '0;
  packet_switch_pkg::SEGMENT_INFO_S [NP-1:0] in_tuser_segment_info = '0;
  logic out_tvalid, out_tlast, out_tready = 1, busy, wdog_evt;
  logic [DW-1:0] out_tdata;
  logic [DW/8-1:0] out_tkeep;
  logic [UW-1:0] out_tuser_usermetadata;
  packet_switch_pkg::SEGMENT_INFO_S out_tuser_segment_info;
  logic [GW-1:0] cur_grant;
  egr_wadj_pkt_arb #(.NUM_PORTS(NP), .TDATA_WIDTH(DW), .USERMETADATA_WIDTH(UW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_tkeep(in_tkeep),
    .in_tlast(in_tlast), .in_tuser_usermetadata(in_tuser_usermetadata),
    .in_tuser_segment_info(in_tuser_segment_info), .in_tready(in_tready),
    .out_tvalid(out_tvalid), .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tuser_usermetadata(out_tuser_usermetadata), .out_tuser_segment_info(out_tuser_segment_info),
    .out_tready(out_tready), .cur_grant(cur_grant), .busy(busy), .wdog_evt(wdog_evt));
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  beat_t src_q [NP][$];
  beat_t exp_q [$];
  int ucnt [NP];
  logic [NP-1:0] acc = '0;
  int m_last = NP - 1, exp_wd = 0, wd_seen = 0, cyc = 0, prev_cyc = 0, n_acc = 0;
  bit gaps = 0, bp = 0, tight = 0, have_prev = 0, prev_end = 0, prev_any = 0, stalled = 0;
  beat_t held;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic gen(int p, int npk, int lmin, int lmax);
    for (int k = 0; k < npk; k++) begin
      int len;
      len = $urandom_range(lmax, lmin);
      for (int j = 0; j < len; j++) begin
        beat_t b;
        b.d = {4'(p), 28'($urandom)};
        b.k = 4'($urandom);
        b.l = (j == len - 1);
        b.u = 1'($urandom);
        b.s.seg_len = 6'($urandom);
        b.s.sop = (j == 0);
        b.s.eop = b.l;
        src_q[p].push_back(b);
      end
    end
  endtask
  // each grant moves one unit: a whole packet, or MB beats with tlast/eop forced
  task automatic build_model();
    int ix [NP];
    int pick, n, q;
    beat_t b;
    for (int p = 0; p < NP; p++) ix[p] = 0;
    while (1) begin
      pick = -1;
      for (int i = 1; i <= NP && pick < 0; i++) begin
        q = (m_last + i) % NP;
        if (ix[q] < src_q[q].size()) pick = q;
      end
      if (pick < 0) break;
      n = 0;
      do begin
        b = src_q[pick][ix[pick]];
        ix[pick]++;
        n++;
        if (!b.l && n == MB) begin
          b.l = 1;
          b.s.eop = 1;
          exp_wd++;
        end
        exp_q.push_back(b);
      end while (!b.l);
      m_last = pick;
    end
  endtask
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (!(in_tvalid[p] && !acc[p])) begin
        if (src_q[p].size() > 0 && (ucnt[p] == 0 || !gaps || $urandom_range(3, 0) != 0)) begin
          in_tvalid[p] = 1;
          {in_tdata[p], in_tkeep[p], in_tlast[p], in_tuser_usermetadata[p], in_tuser_segment_info[p]} = src_q[p][0];
        end else in_tvalid[p] = 0;
      end
    end
    out_tready = bp ? ($urandom_range(2, 0) != 0) : 1'b1;
  endtask
  task automatic sample();
    beat_t got;
    bit any_acc;
    any_acc = 0;
    got = {out_tdata, out_tkeep, out_tlast, out_tuser_usermetadata, out_tuser_segment_info};
    chk("ready_onehot", $countones(in_tready) <= 1, 1);
    for (int p = 0; p < NP; p++) begin
      acc[p] = in_tvalid[p] & in_tready[p];
      if (acc[p]) begin
        any_acc = 1;
        n_acc++;
        chk("grant", cur_grant, p);
        if (tight && have_prev) chk("accept_gap", cyc - prev_cyc, prev_end ? 2 : 1);
        have_prev = 1;
        prev_cyc = cyc;
        prev_end = src_q[p][0].l || ucnt[p] == MB - 1;
        ucnt[p] = prev_end ? 0 : ucnt[p] + 1;
        void'(src_q[p].pop_front());
      end
    end
    if (stalled) begin
      chk("stall_valid", out_tvalid, 1);
      if (out_tvalid) chk("stall_hold", got, held);
    end
    if (out_tvalid && out_tready) begin
      chk("beat_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("beat", got, exp_q.pop_front());
      if (tight) chk("latency", prev_any, 1);
    end
    stalled = out_tvalid && !out_tready;
    held = got;
    if (wdog_evt) wd_seen++;
    prev_any = any_acc;
    cyc++;
  endtask
  task automatic step();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    sample();
  endtask
  task automatic run_phase(bit g, bit b, bit t);
    int left;
    gaps = g; bp = b; tight = t; have_prev = 0; wd_seen = 0; exp_wd = 0;
    build_model();
    for (int c = 0; c < 4000 && exp_q.size() > 0; c++) step();
    chk("phase_done", exp_q.size(), 0);
    repeat (2) step();
    chk("wdog_count", wd_seen, exp_wd);
    left = 0;
    for (int p = 0; p < NP; p++) left += src_q[p].size();
    chk("src_drained", left, 0);
  endtask
  initial begin
    for (int p = 0; p < NP; p++) ucnt[p] = 0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_tready", in_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", cur_grant, 0);
    chk("rst_wdog", wdog_evt, 0);
    @(posedge clk);
    #1 rst = 0;
    for (int p = 0; p < NP; p++) gen(p, 1, 3, 3);
    run_phase(0, 0, 1);
    gen(3, 10, 1, 1);
    run_phase(0, 0, 1);
    gen(0, 1, 6, 6);
    run_phase(0, 0, 1);
    gen(1, 1, 4, 4);
    run_phase(0, 1, 0);
    gen(2, 1, 4, 4);
    gen(1, 1, 2, 2);
    run_phase(0, 0, 1);
    for (int r = 0; r < 25; r++) begin
      for (int p = 0; p < NP; p++) if ($urandom_range(1, 0) != 0) gen(p, $urandom_range(3, 1), 1, 7);
      run_phase(1, 1, 0);
    end
    gen(1, 1, 3, 3);
    gaps = 0; bp = 0; tight = 0; exp_wd = 0;
    build_model();
    n_acc = 0;
    for (int c = 0; c < 50 && n_acc < 2; c++) step();
    @(posedge clk);
    #1 chk("pre_rst_valid", out_tvalid, 1);
    rst = 1;
    #1 chk("midrst_tvalid", out_tvalid, 0);
    chk("midrst_tready", in_tready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_grant", cur_grant, 0);
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      ucnt[p] = 0;
    end
    exp_q.delete();
    in_tvalid = '0;
    acc = '0;
    stalled = 0;
    m_last = NP - 1;
    @(posedge clk);
    #1 rst = 0;
    for (int p = NP - 1; p >= 0; p--) gen(p, 1, 2, 2);
    run_phase(0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
